// File: rtl/tone_meter.sv
// tone_meter: measures period and high time of an asynchronous square wave
// in clk cycles, reports each completed period, and tracks lock and silence.
module tone_meter #(
    parameter int CNT_W   = 20,
    parameter int TIMEOUT = 1000000,
    parameter int TOL     = 2
) (
    input  logic             clk,
    input  logic             _reset,
    input  logic             tone_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             period_valid,
    output logic             locked,
    output logic             silent,
    output logic [15:0]      meas_count
);

    localparam logic [CNT_W-1:0] LP_TIMEOUT = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] LP_TOL     = CNT_W'(TOL);
    localparam logic [CNT_W-1:0] LP_ONE     = CNT_W'(1);

    typedef enum logic {ST_IDLE, ST_MEASURE} state_t;

    state_t           r_state;
    logic             r_s1, r_s2, r_s3;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_hi_cap;
    logic [CNT_W-1:0] r_prev_period;
    logic             r_have_prev;
    logic [CNT_W-1:0] r_period;
    logic [CNT_W-1:0] r_high_time;
    logic             r_valid;
    logic             r_locked;
    logic             r_silent;
    logic [15:0]      r_meas_count;

    logic             w_rise, w_fall;
    logic [CNT_W-1:0] w_diff;

    // Both edges see the same synchroniser latency, so it cancels out of
    // every measured interval.
    assign w_rise = r_s2 & ~r_s3;
    assign w_fall = ~r_s2 & r_s3;

    // Unsigned distance between this period and the previous one.
    assign w_diff = (r_cnt >= r_prev_period) ? (r_cnt - r_prev_period)
                                             : (r_prev_period - r_cnt);

    // Two-flop synchroniser plus a history flop for edge detection.
    always_ff @(posedge clk) begin
        if (!_reset) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= tone_in;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    // Measurement FSM: the first rise arms the counter, each later rise
    // closes a period; running TIMEOUT cycles without a rise drops to IDLE.
    always_ff @(posedge clk) begin
        if (!_reset) begin
            r_state       <= ST_IDLE;
            r_cnt         <= '0;
            r_hi_cap      <= '0;
            r_prev_period <= '0;
            r_have_prev   <= 1'b0;
            r_period      <= '0;
            r_high_time   <= '0;
            r_valid       <= 1'b0;
            r_locked      <= 1'b0;
            r_silent      <= 1'b1;
            r_meas_count  <= '0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_cnt <= '0;
                    if (w_rise) begin
                        r_state     <= ST_MEASURE;
                        r_cnt       <= LP_ONE;
                        r_have_prev <= 1'b0;
                    end
                end
                ST_MEASURE: begin
                    if (w_fall)
                        r_hi_cap <= r_cnt;
                    // A rise landing on the timeout cycle still counts.
                    if (w_rise) begin
                        r_period      <= r_cnt;
                        r_high_time   <= r_hi_cap;
                        r_valid       <= 1'b1;
                        r_meas_count  <= r_meas_count + 16'd1;
                        r_silent      <= 1'b0;
                        r_prev_period <= r_cnt;
                        r_have_prev   <= 1'b1;
                        r_cnt         <= LP_ONE;
                        if (r_have_prev)
                            r_locked <= (w_diff <= LP_TOL);
                    end else if (r_cnt == LP_TIMEOUT) begin
                        r_state     <= ST_IDLE;
                        r_silent    <= 1'b1;
                        r_locked    <= 1'b0;
                        r_have_prev <= 1'b0;
                        r_cnt       <= '0;
                    end else begin
                        r_cnt <= r_cnt + LP_ONE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign period       = r_period;
    assign high_time    = r_high_time;
    assign period_valid = r_valid;
    assign locked       = r_locked;
    assign silent       = r_silent;
    assign meas_count   = r_meas_count;

endmodule
